// File: rtl/cla_sub_seq_if.sv
// Handshake/operand bundle for cla_sub_seq: start/operands in, busy/done/result out.
interface cla_sub_seq_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;

    modport master (output start, a, b, bin, input  busy, done, d, bout, zero);
    modport slave  (input  start, a, b, bin, output busy, done, d, bout, zero);
endinterface

// File: rtl/cla_sub_seq.sv
// Nibble-serial borrow-lookahead subtractor d = a - b - bin, LSB nibble first.
// Optional macro CLA_SUB_SAT_EN: clamp d to 0 when the final borrow is 1.
module cla_sub_seq #(
    parameter int WIDTH = 16  // multiple of 4, >= 4
) (
    input  logic          clk,
    input  logic          rst_n,
    cla_sub_seq_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bw_q, bw_d;
    logic [KW-1:0]    k_q, k_d;
    logic             bout_q, bout_d, zero_q, zero_d;

    logic [3:0]       na, nb, g, p, nd;
    logic [4:0]       bw;
    logic [WIDTH-1:0] res;

    // Current nibble, borrows expanded flat so no ripple inside the slice.
    always_comb begin
        na = a_q[{k_q, 2'b00} +: 4];
        nb = b_q[{k_q, 2'b00} +: 4];
        g  = ~na & nb;
        p  = ~(na ^ nb);
        bw[0] = bw_q;
        bw[1] = g[0] | (p[0] & bw_q);
        bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bw_q);
        bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bw_q);
        bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bw_q);
        nd  = na ^ nb ^ bw[3:0];
        res = acc_q;
        res[{k_q, 2'b00} +: 4] = nd;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        bw_d    = bw_q;
        k_d     = k_q;
        d_d     = d_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    bw_d    = bus.bin;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = res;
                bw_d  = bw[4];
                k_d   = k_q + 1'b1;
                if (k_q == KW'(NIB - 1)) begin
                    state_d = DONE;
                    bout_d  = bw[4];
`ifdef CLA_SUB_SAT_EN
                    d_d     = bw[4] ? '0 : res;
                    zero_d  = bw[4] | (res == '0);
`else
                    d_d     = res;
                    zero_d  = (res == '0);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            bw_q    <= 1'b0;
            k_q     <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            bw_q    <= bw_d;
            k_q     <= k_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_cla_sub_seq.sv
// Directed bench for cla_sub_seq (WIDTH=16), honours CLA_SUB_SAT_EN expectations.
module tb_cla_sub_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    cla_sub_seq_if #(.WIDTH(16)) bus ();
    cla_sub_seq #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

`ifdef CLA_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Drives one op and observes 10 cycles after the start edge; comparisons stay in the tests.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                         output int busy_cnt, output int done_cyc, output int done_cnt);
        @(negedge clk);
        bus.a = ta; bus.b = tb_; bus.bin = tbin; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        busy_cnt = 0; done_cyc = -1; done_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        total++; if (bus.d !== 16'h0000) begin bad++; $display("FAIL reset_d got=%h exp=0000", bus.d); end
        total++; if (bus.bout !== 1'b0) begin bad++; $display("FAIL reset_bout got=%b exp=0", bus.bout); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", bus.zero); end
    endtask

    task automatic test_basic;
        int bc, dc, dn;
        do_op(16'h1234, 16'h0034, 1'b0, bc, dc, dn);
        total++; if (bc != 4) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
        total++; if (dc != 5) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=5", dc); end
        total++; if (dn != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", dn); end
        total++; if (bus.d !== 16'h1200) begin bad++; $display("FAIL basic_d got=%h exp=1200", bus.d); end
        total++; if (bus.bout !== 1'b0) begin bad++; $display("FAIL basic_bout got=%b exp=0", bus.bout); end
        total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL basic_zero got=%b exp=0", bus.zero); end
    endtask

    task automatic test_underflow;
        int bc, dc, dn;
        do_op(16'h0000, 16'h0001, 1'b0, bc, dc, dn);
        total++; if (dc != 5) begin bad++; $display("FAIL uflow_done_cycle got=%0d exp=5", dc); end
        total++; if (bus.d !== (SAT ? 16'h0000 : 16'hFFFF)) begin bad++; $display("FAIL uflow_d got=%h exp=%h", bus.d, SAT ? 16'h0000 : 16'hFFFF); end
        total++; if (bus.bout !== 1'b1) begin bad++; $display("FAIL uflow_bout got=%b exp=1", bus.bout); end
        total++; if (bus.zero !== SAT) begin bad++; $display("FAIL uflow_zero got=%b exp=%b", bus.zero, SAT); end
    endtask

    task automatic test_equal;
        int bc, dc, dn;
        do_op(16'hABCD, 16'hABCD, 1'b0, bc, dc, dn);
        total++; if (bus.d !== 16'h0000) begin bad++; $display("FAIL eq_d got=%h exp=0000", bus.d); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL eq_zero got=%b exp=1", bus.zero); end
        total++; if (bus.bout !== 1'b0) begin bad++; $display("FAIL eq_bout got=%b exp=0", bus.bout); end
        do_op(16'hABCD, 16'hABCD, 1'b1, bc, dc, dn);
        total++; if (bus.d !== (SAT ? 16'h0000 : 16'hFFFF)) begin bad++; $display("FAIL eqbin_d got=%h exp=%h", bus.d, SAT ? 16'h0000 : 16'hFFFF); end
        total++; if (bus.bout !== 1'b1) begin bad++; $display("FAIL eqbin_bout got=%b exp=1", bus.bout); end
        total++; if (bus.zero !== SAT) begin bad++; $display("FAIL eqbin_zero got=%b exp=%b", bus.zero, SAT); end
    endtask

    task automatic test_chain_ignore;
        int bc, dc, dn;
        do_op(16'h1000, 16'h0001, 1'b0, bc, dc, dn);
        total++; if (bus.d !== 16'h0FFF) begin bad++; $display("FAIL chain_d got=%h exp=0FFF", bus.d); end
        total++; if (bus.bout !== 1'b0) begin bad++; $display("FAIL chain_bout got=%b exp=0", bus.bout); end
        // Second op: a new start with new operands lands in RUN and must be dropped.
        @(negedge clk);
        bus.a = 16'h0005; bus.b = 16'h0003; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dc = -1; dn = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) begin
                bus.a = 16'hFFFF; bus.b = 16'h0000; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                dn++;
                if (dc < 0) dc = c;
            end
        end
        total++; if (dc != 5) begin bad++; $display("FAIL ign_done_cycle got=%0d exp=5", dc); end
        total++; if (dn != 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", dn); end
        total++; if (bus.d !== 16'h0002) begin bad++; $display("FAIL ign_d got=%h exp=0002", bus.d); end
    endtask

    task automatic test_abort;
        int bc, dc, dn;
        @(negedge clk);
        bus.a = 16'h00F0; bus.b = 16'h0001; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        total++; if (bus.d !== 16'h0000) begin bad++; $display("FAIL abort_d got=%h exp=0000", bus.d); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL abort_zero got=%b exp=1", bus.zero); end
        dn = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        total++; if (dn != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dn); end
        do_op(16'h0100, 16'h0001, 1'b0, bc, dc, dn);
        total++; if (bus.d !== 16'h00FF) begin bad++; $display("FAIL after_abort_d got=%h exp=00FF", bus.d); end
        total++; if (dc != 5) begin bad++; $display("FAIL after_abort_done_cycle got=%0d exp=5", dc); end
    endtask

    task automatic test_back_to_back;
        int d1, d2, dn;
        @(negedge clk);
        bus.a = 16'h0010; bus.b = 16'h0008; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        d1 = -1; d2 = -1; dn = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) begin bus.a = 16'h0003; bus.b = 16'h0005; end
            if (c == 6) bus.start = 1'b0;
            if (bus.done) begin
                dn++;
                if (dn == 1) begin
                    d1 = c;
                    total++; if (bus.d !== 16'h0008) begin bad++; $display("FAIL b2b_d1 got=%h exp=0008", bus.d); end
                    total++; if (bus.bout !== 1'b0) begin bad++; $display("FAIL b2b_bout1 got=%b exp=0", bus.bout); end
                end else if (dn == 2) begin
                    d2 = c;
                    total++; if (bus.d !== (SAT ? 16'h0000 : 16'hFFFE)) begin bad++; $display("FAIL b2b_d2 got=%h exp=%h", bus.d, SAT ? 16'h0000 : 16'hFFFE); end
                    total++; if (bus.bout !== 1'b1) begin bad++; $display("FAIL b2b_bout2 got=%b exp=1", bus.bout); end
                end
            end
        end
        bus.start = 1'b0;
        total++; if (dn != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", dn); end
        total++; if (d1 != 5) begin bad++; $display("FAIL b2b_first_done got=%0d exp=5", d1); end
        total++; if (d2 - d1 != 5) begin bad++; $display("FAIL b2b_spacing got=%0d exp=5", d2 - d1); end
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_basic;
        test_underflow;
        test_equal;
        test_chain_ignore;
        test_abort;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
